code_decode_display: RTL and testbench
======================================

Name: code_decode_display

Overview:
- Reverse direction of the board's 8-to-3 priority encoder.
- Accepts a 4-bit encoded code {valid flag, 3-bit index} over a valid/ready handshake.
- Registers the code, decodes it to an 8-bit one-hot LED vector and an active-low seven-segment digit.
- Holds each accepted code for a minimum display time before accepting the next. Sits between the encoder/switch logic and the LED/seg0 pins.

Parameters:
- HOLD_CYCLES, 4, minimum cycles each accepted code stays displayed before in_ready reasserts; legal range >= 1
- BLINK_LOG2, 3, blink half-period is 2^BLINK_LOG2 cycles; used only with the optional feature

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  block enable; low forces the idle/cleared condition
- in_valid  input  1  in_code is presented
- in_code  input  4  bit3 = code-valid flag, bits2:0 = index
- in_ready  output  1  block accepts in_code this cycle
- led  output  8  one-hot decode: led[index] = 1 when code valid, else 0
- seg0  output  8  active-low segments {a,b,c,d,e,f,g,dp}
- shown  output  1  a code is currently latched and displayed
- busy  output  1  hold timer running

Behaviour:
- Clocking and reset
  - Single clock. Reset is synchronous and active-high, sampled on rising clk.
  - Reset values: led=0, seg0=8'hFF (blank), shown=0, busy=0, in_ready=0 during the reset cycle, state=IDLE, hold counter=0, blink counter=0.
- Handshake
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - in_code is sampled only on a transfer.
  - in_ready is combinational from state and counter only, never from in_valid.
- States and transitions
  - IDLE: in_ready = en, shown=0, busy=0, outputs blank (led=0, seg0=FF). Transfer -> HOLD.
  - HOLD: in_ready=0, busy=1. Counter loaded with HOLD_CYCLES-1 on transfer; decrements each cycle. Counter==0 -> READY.
  - READY: in_ready=1, busy=0. Display persists. Transfer -> HOLD (reload).
  - HOLD_CYCLES==1: the HOLD state is skipped; a transfer goes directly to READY with the display updated.
- Timing
  - Transfer at edge N -> led/seg0/shown reflect the new code after edge N (visible in cycle N+1).
  - Next transfer possible no earlier than edge N+HOLD_CYCLES, giving a back-to-back spacing of exactly HOLD_CYCLES cycles.
- Decode
  - Code valid (in_code[3]=1): led = 1<<index. seg0 = ~pattern(index), where digit = index.
    - Patterns (active-high abcdefg dp): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0.
  - Code invalid (in_code[3]=0): led=0, seg0=~8'h02 (dash, g only), shown=1.
- Enable
  - en low, any state: next edge -> IDLE, outputs cleared, counter=0.
  - en low: in_ready=0, so no transfer can occur. A code presented in that same cycle is not accepted.
- Reset mid-hold: rst wins over en and any transfer; all state returns to reset values.
- in_valid held high with a changing in_code during HOLD: ignored; only the value present at the transfer edge is used.

Optional Feature:
- Macro: DECODE_BLINK_EN
- Defined:
  - A free-running counter of BLINK_LOG2+1 bits is cleared by rst.
  - While an invalid code is shown, seg0 alternates dash/blank; it shows dash when counter MSB = 0.
  - Valid codes and led are unaffected.
- Undefined: no counter is instantiated; the dash is steady.

Decomposition:
- Package dec_pkg:
  - State enum {IDLE, HOLD, READY}.
  - SEG_BLANK=8'hFF and SEG_DASH=~8'h02.
  - 8-entry active-high digit-pattern constant array.
- Sub-module seg7_lut: combinational 3-bit index -> 8-bit active-low pattern. It is reusable by other display blocks.
- Top: FSM, hold counter, output registers, blink logic.

Test Plan:
- Reset, en=1, in_valid=1, in_code=4'b1101 -> after the transfer, led=8'b00100000, seg0=~8'hB6, shown=1, busy=1.
  - in_ready stays low 3 cycles, then reasserts with HOLD_CYCLES=4.
- Back-to-back codes 4'b1000 then 4'b1111 with in_valid held high -> transfers exactly 4 cycles apart.
  - led: 8'h01 then 8'h80. seg0: ~FC then ~E0.
- in_code=4'b0xxx -> led=0, seg0=~8'h02, shown=1.
  - With DECODE_BLINK_EN and BLINK_LOG2=3: seg0 toggles dash/FF every 8 cycles.
- Drop en mid-HOLD -> next edge: led=0, seg0=FF, shown=0, in_ready=0.
  - Re-raise en -> in_ready=1 in IDLE.
- Assert rst during HOLD with in_valid=1 -> all outputs at reset values the next cycle; no transfer recorded.
- HOLD_CYCLES=1 build -> in_ready remains 1 while en=1; every cycle with in_valid updates led on the following edge.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and seven-segment constants for the code decode/display path.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    READY
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = ~8'h02;

  // Active-high {a,b,c,d,e,f,g,dp} patterns for digits 0..7.
  localparam logic [7:0] DIGIT_PAT [8] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0
  };

endpackage

// File: rtl/seg7_lut.sv
// Combinational 3-bit digit index to active-low seven-segment pattern.
module seg7_lut
  import dec_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [7:0] seg_o
);

  assign seg_o = ~DIGIT_PAT[idx_i];

endmodule

// File: rtl/code_decode_display.sv
// Accepts {valid, index} codes over valid/ready, drives one-hot LEDs and seg0 for
// at least HOLD_CYCLES per code. Define DECODE_BLINK_EN to blink the invalid-code dash.
module code_decode_display
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned BLINK_LOG2  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  output logic       in_ready,
  output logic [7:0] led,
  output logic [7:0] seg0,
  output logic       shown,
  output logic       busy
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    seg_q, seg_d;
  logic          shown_q, shown_d;
  logic [7:0]    lut_seg;
  logic          xfer;

  seg7_lut u_lut (
    .idx_i (in_code[2:0]),
    .seg_o (lut_seg)
  );

  // Depends on state only (plus en/rst), never on in_valid.
  assign in_ready = en & ~rst & (state_q != HOLD);
  assign xfer     = in_valid & in_ready;
  assign busy     = (state_q == HOLD);
  assign led      = led_q;
  assign shown    = shown_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    seg_d   = seg_q;
    shown_d = shown_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      led_d   = '0;
      seg_d   = SEG_BLANK;
      shown_d = 1'b0;
    end else if (xfer) begin
      state_d = (HOLD_CYCLES == 1) ? READY : HOLD;
      cnt_d   = HOLD_LOAD;
      led_d   = in_code[3] ? (8'b1 << in_code[2:0]) : 8'h00;
      seg_d   = in_code[3] ? lut_seg : SEG_DASH;
      shown_d = 1'b1;
    end else if (state_q == HOLD) begin
      // Leaving on the count that would reach zero gives a spacing of exactly HOLD_CYCLES.
      if (cnt_q <= CW'(1)) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking (<=) so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      seg_q   <= SEG_BLANK;
      shown_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
      shown_q <= shown_d;
    end
  end

`ifdef DECODE_BLINK_EN
  logic [BLINK_LOG2:0] blink_q;

  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + (BLINK_LOG2 + 1)'(1);
  end

  // An invalid code is the only displayed state with no LED lit.
  assign seg0 = (shown_q && (led_q == 8'h00) && blink_q[BLINK_LOG2]) ? SEG_BLANK : seg_q;
`else
  assign seg0 = seg_q;
`endif

endmodule

// File: tb/tb_code_decode_display.sv
// Scoreboard bench: the driver queues expected displays, a monitor checks them on each transfer.
module tb_code_decode_display;

  logic       clk, rst, en, in_valid, in_valid1;
  logic [3:0] in_code;
  logic       in_ready, shown, busy;
  logic [7:0] led, seg0;
  logic       in_ready1, shown1, busy1;
  logic [7:0] led1, seg1;

  code_decode_display #(.HOLD_CYCLES(4), .BLINK_LOG2(3)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .led(led), .seg0(seg0), .shown(shown), .busy(busy)
  );

  code_decode_display #(.HOLD_CYCLES(1), .BLINK_LOG2(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid1), .in_code(in_code),
    .in_ready(in_ready1), .led(led1), .seg0(seg1), .shown(shown1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic [7:0] seg;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // A blinking dash may legitimately read as blank in the blink build.
  function automatic logic [7:0] seg_req(input logic [7:0] act, input logic [7:0] exp_seg);
`ifdef DECODE_BLINK_EN
    if (exp_seg == 8'hFD && act == 8'hFF) return 8'hFF;
`endif
    return exp_seg;
  endfunction

  // Monitor: note transfers at the edge, compare the display half a cycle later.
  logic xfer_seen = 1'b0;
  int   cyc = 0, last_cyc = 0, gap_seen = 0;

  always @(posedge clk) begin
    cyc++;
    xfer_seen = in_valid && in_ready;
    if (xfer_seen) begin
      gap_seen = cyc - last_cyc;
      last_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (xfer_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_xfer: got transfer of code 0x%0h, expected none at %0t", in_code, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_led", led, e.led);
        check("sb_seg0", seg0, seg_req(seg0, e.seg));
        check("sb_shown", shown, 1);
        check("sb_busy", busy, 1);
        if (e.gap >= 0) check("sb_gap", gap_seen, e.gap);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] b2b_codes [4] = '{4'b1010, 4'b1100, 4'b1111, 4'b1111};
  logic [3:0] h1_codes  [5] = '{4'b1000, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
  logic [7:0] h1_led    [5] = '{8'h01, 8'h08, 8'h00, 8'h40, 8'h20};
  logic [7:0] h1_seg    [5] = '{8'h03, 8'h0D, 8'hFD, 8'h41, 8'h49};
  int n_blank, n_dash;

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; in_code = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_led", led, 0);
    check("rst_seg0", seg0, 8'hFF);
    check("rst_shown", shown, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    check("idle_ready_h1", in_ready1, 1);

    // Single code 5, then three cycles of in_ready low.
    in_valid = 1'b1; in_code = 4'b1101; exp_q.push_back('{8'h20, 8'h49, -1});
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_low%0d", i), in_ready, 0);
      @(negedge clk);
    end
    check("hold_release", in_ready, 1);
    check("ready_busy", busy, 0);
    check("ready_led_kept", led, 8'h20);

    // Back-to-back codes with in_valid held; in_code churns during HOLD.
    in_valid = 1'b1; in_code = 4'b1000; exp_q.push_back('{8'h01, 8'h03, 4});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_code = b2b_codes[i];
      if (i == 2) exp_q.push_back('{8'h80, 8'h1F, 4});
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("wait_ready", in_ready, 1);

    // Invalid code shows the dash.
    in_valid = 1'b1; in_code = 4'b0101; exp_q.push_back('{8'h00, 8'hFD, -1});
    @(negedge clk);
    in_valid = 1'b0;
    n_blank = 0; n_dash = 0;
    for (int i = 0; i < 16; i++) begin
      if (seg0 == 8'hFF) n_blank++;
      else if (seg0 == 8'hFD) n_dash++;
      @(negedge clk);
    end
`ifdef DECODE_BLINK_EN
    check("blink_blank", n_blank, 8);
    check("blink_dash", n_dash, 8);
`else
    check("dash_steady", n_dash, 16);
`endif

    // Drop en mid-HOLD while a new code is offered.
    in_valid = 1'b1; in_code = 4'b1011; exp_q.push_back('{8'h08, 8'h0D, -1});
    @(negedge clk);
    en = 1'b0; in_code = 4'b1110;
    #1 check("en_low_ready", in_ready, 0);
    @(negedge clk);
    check("en_low_led", led, 0);
    check("en_low_seg0", seg0, 8'hFF);
    check("en_low_shown", shown, 0);
    check("en_low_busy", busy, 0);
    @(negedge clk);
    check("en_low_no_accept", led, 0);
    in_valid = 1'b0; en = 1'b1;
    #1 check("en_high_ready", in_ready, 1);

    // Reset during HOLD with in_valid high.
    @(negedge clk);
    in_valid = 1'b1; in_code = 4'b1001; exp_q.push_back('{8'h02, 8'h9F, -1});
    @(negedge clk);
    rst = 1'b1; in_code = 4'b1100;
    #1 check("rst_cycle_ready", in_ready, 0);
    @(negedge clk);
    check("rst_hold_led", led, 0);
    check("rst_hold_seg0", seg0, 8'hFF);
    check("rst_hold_shown", shown, 0);
    check("rst_hold_busy", busy, 0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    check("post_rst_led", led, 0);

    // HOLD_CYCLES=1 instance accepts a code every cycle.
    in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code = h1_codes[i];
      @(negedge clk);
      check($sformatf("h1_led%0d", i), led1, h1_led[i]);
      check($sformatf("h1_seg%0d", i), seg1, seg_req(seg1, h1_seg[i]));
      check($sformatf("h1_ready%0d", i), in_ready1, 1);
      check($sformatf("h1_busy%0d", i), busy1, 0);
    end
    in_valid1 = 1'b0;

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
